// File: rtl/tx_sequencer.sv
// tx_sequencer: transmit-side connection controller for the lasernet link.
//
// Walks makepacket through SYN -> NPKT data packets -> FIN. For each packet it
// loads seq/ack/flags, pulses mk_readyin for one cycle, waits for makepacket to
// report the packet built (mk_readyout), then waits for the matching ACK from
// the peer. Unacknowledged packets are retransmitted after TIMEOUT cycles, up
// to MAX_RETRY times, before the connection is declared failed.
//
// Ports
//   clk          system clock
//   reset        synchronous active-low reset (0 = reset)
//   start        1-cycle pulse: open a connection and send one message
//   ISN          initial sequence number, sampled when start is accepted
//   rx_valid     1-cycle strobe: decoded received header is valid
//   rx_seq       received sequence number
//   rx_ack       received acknowledgement number
//   rx_flags     received flags (bit0 FIN, 1 SYN, 2 RST, 3 PSH, 4 ACK)
//   mk_readyin   1-cycle trigger to makepacket
//   mk_seq       seq field to makepacket
//   mk_ack       ack field to makepacket
//   mk_flags     flags to makepacket
//   mk_window    advertised window (constant WINDOW)
//   mk_readyout  makepacket packet-ready strobe
//   busy         connection in progress
//   done         message fully acknowledged
//   fail         connection aborted (RST, retries exhausted or builder stall)
//   retry_count  retransmissions of the current packet
module tx_sequencer #(
    parameter int          NPKT      = 5,
    parameter int          TIMEOUT   = 1_000_000,
    parameter int          MAX_RETRY = 3,
    parameter logic [15:0] WINDOW    = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ISN,
    input  logic        rx_valid,
    input  logic [31:0] rx_seq,
    input  logic [31:0] rx_ack,
    input  logic [8:0]  rx_flags,
    output logic        mk_readyin,
    output logic [31:0] mk_seq,
    output logic [31:0] mk_ack,
    output logic [8:0]  mk_flags,
    output logic [15:0] mk_window,
    input  logic        mk_readyout,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [1:0]  retry_count
);

    localparam int IW = (NPKT > 1) ? $clog2(NPKT) : 1;

    localparam logic [8:0] FL_FIN = 9'h001;
    localparam logic [8:0] FL_SYN = 9'h002;
    localparam logic [8:0] FL_PSH = 9'h008;
    localparam logic [8:0] FL_ACK = 9'h010;

    // makepacket should answer in 2 cycles; 16 cycles of silence means it is stuck.
    localparam logic [31:0] BLD_LAST = 32'd15;
    localparam logic [31:0] ACK_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_BLD, S_WAIT_ACK, S_DONE, S_FAIL
    } state_t;

    typedef enum logic [1:0] {
        PH_SYN, PH_DATA, PH_FIN
    } phase_t;

    state_t        state_reg, state_next;
    phase_t        phase_reg, phase_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [1:0]    retry_reg, retry_next;
    logic [31:0]   timer_reg, timer_next;
    logic [31:0]   isn_reg, isn_next;
    logic [31:0]   peer_reg, peer_next;
    logic [31:0]   seq_reg, seq_next;
    logic [31:0]   ack_reg, ack_next;
    logic [8:0]    flags_reg, flags_next;

    logic busy_int;
    logic rx_rst;
    logic ack_match;

    // Only the ACK, SYN and RST flags steer this controller.
    logic unused_rx_flags;
    assign unused_rx_flags = &{1'b0, rx_flags[8:5], rx_flags[3], rx_flags[0]};

    assign busy_int = (state_reg == S_SEND) || (state_reg == S_WAIT_BLD) ||
                      (state_reg == S_WAIT_ACK);
    assign rx_rst   = rx_valid && rx_flags[2];

    // A valid ACK acknowledges exactly the packet in flight (mod 2^32); during
    // the handshake it must also carry SYN.
    assign ack_match = rx_valid && rx_flags[4] &&
                       (rx_ack == seq_reg + 32'd1) &&
                       ((phase_reg != PH_SYN) || rx_flags[1]);

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        idx_next   = idx_reg;
        retry_next = retry_reg;
        timer_next = timer_reg;
        isn_next   = isn_reg;
        peer_next  = peer_reg;
        seq_next   = seq_reg;
        ack_next   = ack_reg;
        flags_next = flags_reg;

        case (state_reg)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    isn_next   = ISN;
                    phase_next = PH_SYN;
                    idx_next   = '0;
                    retry_next = 2'd0;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                state_next = S_WAIT_BLD;
                timer_next = 32'd0;
            end
            S_WAIT_BLD: begin
                if (mk_readyout) begin
                    state_next = S_WAIT_ACK;
                    timer_next = 32'd0;
                end else if (timer_reg == BLD_LAST) begin
                    state_next = S_FAIL;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end
            S_WAIT_ACK: begin
                timer_next = timer_reg + 32'd1;
                // A match in the timeout cycle still counts as a match.
                if (ack_match) begin
                    retry_next = 2'd0;
                    case (phase_reg)
                        PH_SYN: begin
                            peer_next  = rx_seq;
                            phase_next = PH_DATA;
                            idx_next   = '0;
                            state_next = S_SEND;
                        end
                        PH_DATA: begin
                            if (idx_reg == IW'(NPKT - 1)) begin
                                phase_next = PH_FIN;
                            end else begin
                                idx_next = idx_reg + 1'b1;
                            end
                            state_next = S_SEND;
                        end
                        default: state_next = S_DONE;
                    endcase
                end else if (timer_reg == ACK_LAST) begin
                    if (retry_reg == 2'(MAX_RETRY)) begin
                        state_next = S_FAIL;
                    end else begin
                        retry_next = retry_reg + 2'd1;
                        state_next = S_SEND;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // A peer reset aborts any active connection, ahead of everything else.
        if (busy_int && rx_rst) begin
            state_next = S_FAIL;
        end

        // Packet fields are loaded on entry to SEND from the next-state phase
        // info, so a retransmission reproduces the same fields.
        if (state_next == S_SEND && state_reg != S_SEND) begin
            case (phase_next)
                PH_SYN: begin
                    seq_next   = isn_next;
                    ack_next   = 32'd0;
                    flags_next = FL_SYN;
                end
                PH_DATA: begin
                    seq_next   = isn_next + 32'd1 + 32'(idx_next);
                    ack_next   = peer_next + 32'd1;
                    flags_next = FL_ACK | FL_PSH;
                end
                default: begin
                    seq_next   = isn_next + 32'(NPKT + 1);
                    ack_next   = peer_next + 32'd1;
                    flags_next = FL_FIN | FL_ACK;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            phase_reg <= PH_SYN;
            idx_reg   <= '0;
            retry_reg <= 2'd0;
            timer_reg <= 32'd0;
            isn_reg   <= 32'd0;
            peer_reg  <= 32'd0;
            seq_reg   <= 32'd0;
            ack_reg   <= 32'd0;
            flags_reg <= 9'd0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            idx_reg   <= idx_next;
            retry_reg <= retry_next;
            timer_reg <= timer_next;
            isn_reg   <= isn_next;
            peer_reg  <= peer_next;
            seq_reg   <= seq_next;
            ack_reg   <= ack_next;
            flags_reg <= flags_next;
        end
    end

    assign mk_readyin  = (state_reg == S_SEND);
    assign mk_seq      = seq_reg;
    assign mk_ack      = ack_reg;
    assign mk_flags    = flags_reg;
    assign mk_window   = WINDOW;
    assign busy        = busy_int;
    assign done        = (state_reg == S_DONE);
    assign fail        = (state_reg == S_FAIL);
    assign retry_count = retry_reg;

endmodule

// File: tb/tb_tx_sequencer.sv
module tb_tx_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] isn;
    logic        rx_valid;
    logic [31:0] rx_seq;
    logic [31:0] rx_ack;
    logic [8:0]  rx_flags;
    logic        mk_readyin;
    logic [31:0] mk_seq;
    logic [31:0] mk_ack;
    logic [8:0]  mk_flags;
    logic [15:0] mk_window;
    logic        mk_readyout;
    logic        busy;
    logic        done;
    logic        fail;
    logic [1:0]  retry_count;

    tx_sequencer #(
        .NPKT(5), .TIMEOUT(50), .MAX_RETRY(3), .WINDOW(16'd1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .ISN(isn),
        .rx_valid(rx_valid), .rx_seq(rx_seq), .rx_ack(rx_ack), .rx_flags(rx_flags),
        .mk_readyin(mk_readyin), .mk_seq(mk_seq), .mk_ack(mk_ack),
        .mk_flags(mk_flags), .mk_window(mk_window), .mk_readyout(mk_readyout),
        .busy(busy), .done(done), .fail(fail), .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pkt_count = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // makepacket stand-in: readyout two cycles after readyin, can be muted.
    logic [1:0] bld_pipe = 2'b00;
    logic       bld_en = 1'b1;
    always @(posedge clk) bld_pipe <= {bld_pipe[0], mk_readyin};
    assign mk_readyout = bld_pipe[1] & bld_en;

    typedef struct {
        logic [31:0] seq;
        logic [31:0] ack;
        logic [8:0]  flags;
        logic [1:0]  retry;
    } pkt_t;

    pkt_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] a,
                        input logic [8:0] f, input logic [1:0] r);
        pkt_t p;
        p.seq = s; p.ack = a; p.flags = f; p.retry = r;
        sb.push_back(p);
    endtask

    // Scoreboard consumer: every readyin pulse is one transmitted packet.
    always @(negedge clk) begin
        if (reset === 1'b1 && mk_readyin === 1'b1) begin
            pkt_t p;
            pkt_count++;
            $display("pkt %0d: seq=%08h ack=%08h flags=%03h retry=%0d win=%0d",
                     pkt_count, mk_seq, mk_ack, mk_flags, retry_count, mk_window);
            if (sb.size() == 0) begin
                check("pkt_unexpected", {32'd0, mk_seq}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                p = sb.pop_front();
                check("pkt_seq",   {32'd0, mk_seq},        {32'd0, p.seq});
                check("pkt_ack",   {32'd0, mk_ack},        {32'd0, p.ack});
                check("pkt_flags", {55'd0, mk_flags},      {55'd0, p.flags});
                check("pkt_retry", {62'd0, retry_count},   {62'd0, p.retry});
                check("pkt_win",   {48'd0, mk_window},     64'd1);
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pkts(input int n);
        for (int i = 0; i < 300 && pkt_count < n; i++) step();
        check("pkt_arrival", {32'd0, pkt_count >= n ? 32'd1 : 32'd0}, 64'd1);
    endtask

    task automatic wait_fail(input int budget);
        for (int i = 0; i < budget && fail !== 1'b1; i++) step();
        check("fail_reached", {63'd0, fail}, 64'd1);
        check("fail_busy",    {63'd0, busy}, 64'd0);
    endtask

    task automatic do_start(input logic [31:0] v);
        isn = v;
        start = 1'b1;
        step();
        start = 1'b0;
        isn = 32'd0;
    endtask

    task automatic rx(input logic [31:0] s, input logic [31:0] a, input logic [8:0] f);
        rx_valid = 1'b1; rx_seq = s; rx_ack = a; rx_flags = f;
        step();
        rx_valid = 1'b0; rx_seq = 32'd0; rx_ack = 32'd0; rx_flags = 9'd0;
    endtask

    // Full message starting at base: SYN, 5 data, FIN, with peer ISN peer.
    task automatic full_message(input logic [31:0] base, input logic [31:0] peer);
        int n;
        n = pkt_count;
        push(base, 32'd0, 9'h002, 2'd0);
        do_start(base);
        wait_pkts(n + 1);
        step(4);
        push(base + 32'd1, peer + 32'd1, 9'h018, 2'd0);
        rx(peer, base + 32'd1, 9'h012);
        for (int i = 0; i < 5; i++) begin
            wait_pkts(n + 2 + i);
            step(4);
            if (i < 4) push(base + 32'd2 + 32'(i), peer + 32'd1, 9'h018, 2'd0);
            else       push(base + 32'd6, peer + 32'd1, 9'h011, 2'd0);
            rx(32'd0, base + 32'd2 + 32'(i), 9'h010);
        end
        wait_pkts(n + 7);
        step(4);
        check("pre_fin_done", {63'd0, done}, 64'd0);
        rx(32'd0, base + 32'd7, 9'h010);
        check("msg_done", {63'd0, done}, 64'd1);
        check("msg_busy", {63'd0, busy}, 64'd0);
        check("msg_fail", {63'd0, fail}, 64'd0);
    endtask

    int n0;
    int t_prev;

    initial begin
        reset = 1'b0; start = 1'b0; isn = 32'd0;
        rx_valid = 1'b0; rx_seq = 32'd0; rx_ack = 32'd0; rx_flags = 9'd0;
        step(3);
        check("rst_busy",    {63'd0, busy},        64'd0);
        check("rst_done",    {63'd0, done},        64'd0);
        check("rst_fail",    {63'd0, fail},        64'd0);
        check("rst_readyin", {63'd0, mk_readyin},  64'd0);
        check("rst_seq",     {32'd0, mk_seq},      64'd0);
        check("rst_retry",   {62'd0, retry_count}, 64'd0);
        reset = 1'b1;
        step(2);

        // Reset while waiting for the SYN-ACK.
        push(32'd100, 32'd0, 9'h002, 2'd0);
        do_start(32'd100);
        check("start_busy", {63'd0, busy}, 64'd1);
        wait_pkts(1);
        step(5);
        reset = 1'b0;
        step();
        check("midrst_busy",  {63'd0, busy},        64'd0);
        check("midrst_seq",   {32'd0, mk_seq},      64'd0);
        check("midrst_ack",   {32'd0, mk_ack},      64'd0);
        check("midrst_flags", {55'd0, mk_flags},    64'd0);
        check("midrst_retry", {62'd0, retry_count}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("midrst_readyin", {63'd0, mk_readyin}, 64'd0);
            step();
        end
        reset = 1'b1;
        step(2);

        // Nominal message.
        full_message(32'd100, 32'd500);

        // Duplicate ack ignored, then retransmit exhaustion on data idx2.
        n0 = pkt_count;
        push(32'd100, 32'd0, 9'h002, 2'd0);
        do_start(32'd100);
        check("restart_done", {63'd0, done}, 64'd0);
        wait_pkts(n0 + 1);
        step(4);
        push(32'd101, 32'd501, 9'h018, 2'd0);
        rx(32'd500, 32'd101, 9'h012);
        wait_pkts(n0 + 2);
        step(4);
        push(32'd102, 32'd501, 9'h018, 2'd0);
        rx(32'd0, 32'd102, 9'h010);
        wait_pkts(n0 + 3);
        step(4);
        rx(32'd0, 32'd102, 9'h010);
        step(6);
        check("dup_nopkt", {32'd0, 32'(pkt_count)}, {32'd0, 32'(n0 + 3)});
        check("dup_busy",  {63'd0, busy}, 64'd1);
        push(32'd103, 32'd501, 9'h018, 2'd0);
        rx(32'd0, 32'd103, 9'h010);
        wait_pkts(n0 + 4);
        t_prev = cyc;
        for (int r = 1; r <= 3; r++) begin
            push(32'd103, 32'd501, 9'h018, 2'(r));
            wait_pkts(n0 + 4 + r);
            check("resend_gap_ok",
                  {63'd0, ((cyc - t_prev) >= 50 && (cyc - t_prev) <= 56) ? 1'b1 : 1'b0}, 64'd1);
            t_prev = cyc;
        end
        wait_fail(80);
        check("retry_nopkt", {32'd0, 32'(pkt_count)}, {32'd0, 32'(n0 + 7)});

        // RST during the data phase.
        n0 = pkt_count;
        push(32'd200, 32'd0, 9'h002, 2'd0);
        do_start(32'd200);
        check("restart_fail", {63'd0, fail}, 64'd0);
        wait_pkts(n0 + 1);
        step(4);
        push(32'd201, 32'd701, 9'h018, 2'd0);
        rx(32'd700, 32'd201, 9'h012);
        wait_pkts(n0 + 2);
        step(4);
        rx(32'd0, 32'd0, 9'h004);
        check("rst_flag_fail", {63'd0, fail}, 64'd1);
        check("rst_flag_busy", {63'd0, busy}, 64'd0);

        // Builder never answers.
        bld_en = 1'b0;
        n0 = pkt_count;
        push(32'd300, 32'd0, 9'h002, 2'd0);
        do_start(32'd300);
        wait_pkts(n0 + 1);
        step(10);
        check("bld_stall_busy", {63'd0, busy}, 64'd1);
        wait_fail(30);
        bld_en = 1'b1;
        step(2);

        // Sequence wrap through zero.
        full_message(32'hFFFF_FFFE, 32'h0000_0010);

        step(5);
        check("sb_empty", {32'd0, 32'(sb.size())}, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
